booth_seq_mult: RTL and testbench
=================================

# booth_seq_mult

Parametrised sequential radix-2 Booth multiplier with a start/done handshake and a runtime signed/unsigned mode. It is the multi-cycle successor to the ALU's single combinational Booth step. It latches two WIDTH-bit operands, performs one Booth add/subtract-and-shift per clock, and presents a registered 2*WIDTH-bit product. It sits behind the ALU's multiply opcode, and the ALU control stalls on `busy`.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
- multiplicand  input  WIDTH  M operand; latched on accepted start
- multiplier  input  WIDTH  Q operand; latched on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when product is valid
- product  output  2*WIDTH  registered result; held until next completion

## Operation
- Internal width N = WIDTH+1. Operands are extended to N bits on accept:
  - Sign-extended if signed_mode=1.
  - Zero-extended if signed_mode=0.
  - One datapath serves both modes.
- Registers:
  - A[N-1:0], accumulator.
  - Q[N:0], extended multiplier plus Booth bit q₋₁ in Q[0].
  - M[N-1:0], extended multiplicand.
  - cnt, iteration counter, ceil(log2(N+1)) bits.
  - state.
- States:
  - IDLE: on start=1, load A=0, Q={ext(multiplier),1'b0}, M=ext(multiplicand), cnt=0, go to RUN. Otherwise remain.
  - RUN: one step per cycle. On Q[1:0]: 01 → A+M; 10 → A−M (A+~M+1); 00/11 → A unchanged. Then arithmetic right shift of {A',Q}: A gets {A'[N-1],A'[N-1:1]}, Q gets {A'[0],Q[N:1]}. cnt increments. After step N (cnt==N-1 at the edge), load product, go to DONE.
  - DONE: done=1 for this single cycle; unconditionally return to IDLE.
- Product extraction: the full 2N-bit result is {A,Q[N:1]}; product is its low 2*WIDTH bits. This is exact in both modes, so no overflow is possible.
- All add/subtract is modulo 2^N; carry-out is discarded.
- start while in RUN or DONE is ignored (not queued).
- signed_mode and operand changes after accept have no effect on the running operation.
- Outputs are registers or decoded from state only: busy = (state==RUN), done = (state==DONE). No combinational path from inputs to outputs.

## Timing
- Reset (async assert, any state): state=IDLE, A=0, Q=0, M=0, cnt=0, product=0, busy=0, done=0.
- Deassertion is synchronous to clk. The first start can be sampled on the first rising edge after rst falls.
- Edge E0 samples start=1 in IDLE. busy=1 from after E0.
- Steps execute on edges E1..E(N).
- After E(N): product valid, done=1, busy=0.
- After E(N+1): done=0, state=IDLE. A new start is sampleable at E(N+1) only if already in IDLE, so it is actually accepted at E(N+2) at the earliest.
- Latency: start edge to done high is N = WIDTH+1 cycles. Issue interval is WIDTH+3 cycles.
- Reset mid-RUN aborts immediately. product is cleared to 0 and no done pulse is generated.
- product changes only on the RUN→DONE edge or on reset.

## Test plan
- Reset: assert rst mid-RUN → busy=0, done=0, product=0 immediately (async). No done pulse follows; the next start is accepted normally.
- Signed, WIDTH=8:
  - −128 × −128 (0x80, 0x80) → product=0x4000.
  - 7 × −3 (0x07, 0xFD) → 0xFFEB.
  - done high exactly 9 cycles after the start edge, for one cycle.
- Unsigned, WIDTH=8:
  - 255 × 255 → 0xFE01.
  - 0x80 × 0x02 → 0x0100.
  - Same operand bits as the signed case give a different result, proving the mode path.
- Handshake:
  - Pulse start again at cycles 3 and 9 of an operation → both ignored.
  - Only one done pulse; product unchanged from the first result.
  - Operands altered during RUN do not affect the result.
- Back-to-back: hold start=1 continuously → operations accepted every WIDTH+3 cycles, each done a single-cycle pulse, and product updates only at each done.
- Parametrisation: WIDTH=4 and WIDTH=16 with random signed/unsigned operands against a reference model. For WIDTH=16, −32768 × −32768 → 0x40000000. Latency = WIDTH+1.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// start/done handshake, runtime signed/unsigned operand mode.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // One extra bit lets unsigned operands ride the signed Booth datapath.
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic signed [N-1:0]   acc;
    logic        [N:0]     q_reg;
    logic signed [N-1:0]   m_reg;
    logic        [CW-1:0]  cnt;

    logic signed [N-1:0]   acc_sum;
    logic signed [N-1:0]   acc_nxt;
    logic        [N:0]     q_nxt;
    logic                  last_step;

    function automatic logic signed [N-1:0] ext(input logic [WIDTH-1:0] v, input logic sm);
        return {sm & v[WIDTH-1], v};
    endfunction

    assign last_step = (cnt == CW'(N - 1));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_comb begin
        acc_sum = acc;
        case (q_reg[1:0])
            2'b01:   acc_sum = acc + m_reg;
            2'b10:   acc_sum = acc - m_reg;
            default: acc_sum = acc;
        endcase
        acc_nxt = acc_sum >>> 1;
        q_nxt   = {acc_sum[0], q_reg[N:1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        q_reg <= {ext(multiplier, signed_mode), 1'b0};
                        m_reg <= ext(multiplicand, signed_mode);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    q_reg <= q_nxt;
                    cnt   <= cnt + CW'(1);
                    // Low 2*WIDTH bits of {A,Q[N:1]} are exact in both modes.
                    if (last_step)
                        product <= {acc_nxt[N-3:0], q_nxt[N:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: directed and random operations at WIDTH=8 against a
// cycle-level behavioural model, plus WIDTH=4 and WIDTH=16 instances.
module tb_booth_seq_mult;

    localparam int N8 = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start = 1'b0, smode = 1'b0;
    logic [7:0]  mcand = '0, mplier = '0;
    logic        busy, done;
    logic [15:0] product;

    logic        st4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;

    logic        st16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    int checks = 0;
    int failures = 0;

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(smode),
        .multiplicand(mcand), .multiplier(mplier),
        .busy(busy), .done(done), .product(product)
    );

    booth_seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4),
        .multiplicand(a4), .multiplier(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    booth_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product of two w-bit operands, truncated to 2*w bits.
    function automatic longint ref_mul(input longint a, input longint b, input int w, input bit sm);
        longint mask = (longint'(1) << w) - 1;
        longint x = a & mask;
        longint y = b & mask;
        if (sm) begin
            if (x[w-1]) x = x - (longint'(1) << w);
            if (y[w-1]) y = y - (longint'(1) << w);
        end
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Model of the WIDTH=8 instance: phase counts cycles since the accepting edge.
    int     m_phase = 0;
    longint m_exp = 0;
    longint m_prod = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_prod  = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_exp   = ref_mul(mcand, mplier, 8, smode);
            end
        end else if (m_phase == N8 + 1) begin
            m_phase = 0;
        end else begin
            if (m_phase == N8) m_prod = m_exp;
            m_phase++;
        end
    end

    always @(negedge clk) begin
        check("busy8", longint'(busy), longint'(m_phase >= 1 && m_phase <= N8));
        check("done8", longint'(done), longint'(m_phase == N8 + 1));
        check("prod8", longint'(product), m_prod);
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input longint lit, input bit use_lit);
        int lat;
        @(negedge clk);
        mcand = a; mplier = b; smode = sm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency8", lat, N8);
        if (use_lit) check("prod8_literal", longint'(product), lit);
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        int lat;
        @(negedge clk);
        a4 = a; b4 = b; sm4 = sm; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        a4 = ~a; b4 = ~b; sm4 = ~sm;
        lat = 0;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency4", lat, 5);
        check("prod4", longint'(prod4), ref_mul(a, b, 4, sm));
        @(negedge clk);
        check("done4_pulse", longint'(done4), 0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        int lat;
        @(negedge clk);
        a16 = a; b16 = b; sm16 = sm; st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        a16 = ~a; b16 = ~b; sm16 = ~sm;
        lat = 0;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("latency16", lat, 17);
        check("prod16", longint'(prod16), ref_mul(a, b, 16, sm));
        @(negedge clk);
        check("done16_pulse", longint'(done16), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int prev;
        int nd;

        #3;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_prod", longint'(product), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op8(8'h80, 8'h80, 1'b1, 64'h4000, 1'b1);
        op8(8'h07, 8'hFD, 1'b1, 64'hFFEB, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0, 64'hFE01, 1'b1);
        op8(8'h80, 8'h02, 1'b0, 64'h0100, 1'b1);
        op8(8'h07, 8'hFD, 1'b0, 64'h06EB, 1'b1);

        // Start pulses during RUN and DONE, with operands and mode disturbed.
        @(negedge clk);
        mcand = 8'h13; mplier = 8'h05; smode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (c == 3 || c == 9) begin
                start = 1'b1;
                mcand = 8'($urandom);
                mplier = 8'($urandom);
                smode = ~smode;
            end else begin
                start = 1'b0;
            end
        end
        check("hs_done_count", dcnt, 1);
        check("hs_prod", longint'(product), 64'h005F);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        mcand = 8'h55; mplier = 8'h33; smode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_prod", longint'(product), 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        op8(8'h0C, 8'h0B, 1'b1, 64'h0084, 1'b1);

        // start held high: one acceptance every WIDTH+3 cycles.
        @(negedge clk);
        start = 1'b1;
        prev = -1;
        nd = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            mcand = 8'($urandom);
            mplier = 8'($urandom);
            smode = 1'($urandom_range(0, 1));
            if (done) begin
                nd++;
                if (prev >= 0) check("b2b_interval", c - prev, 11);
                prev = c;
            end
        end
        start = 1'b0;
        check("b2b_done_count", nd, 4);
        repeat (14) @(negedge clk);

        for (int i = 0; i < 150; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0);

        for (int i = 0; i < 40; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        run4(4'h8, 4'h8, 1'b1);
        run4(4'hF, 4'hF, 1'b0);

        run16(16'h8000, 16'h8000, 1'b1);
        check("prod16_literal", longint'(prod16), 64'h40000000);
        run16(16'hFFFF, 16'hFFFF, 1'b0);
        check("prod16_unsigned_max", longint'(prod16), 64'hFFFE0001);
        for (int i = 0; i < 40; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
